// File: rtl/alu_regfile_sequencer_if.sv
// Command, host-load and response channels between a host and the ALU/register-file sequencer.
interface alu_regfile_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [4:0]  cmd_rd;
  logic [4:0]  cmd_ra;
  logic [4:0]  cmd_rb;
  logic        ld_en;
  logic [4:0]  ld_addr;
  logic [15:0] ld_data;
  logic        ld_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [8:0]  rsp_result;
  logic [4:0]  rsp_rd;

  modport master (
    output cmd_valid, cmd_op, cmd_rd, cmd_ra, cmd_rb, ld_en, ld_addr, ld_data, rsp_ready,
    input  cmd_ready, ld_ready, rsp_valid, rsp_result, rsp_rd
  );
  modport slave (
    input  cmd_valid, cmd_op, cmd_rd, cmd_ra, cmd_rb, ld_en, ld_addr, ld_data, rsp_ready,
    output cmd_ready, ld_ready, rsp_valid, rsp_result, rsp_rd
  );
endinterface

// File: rtl/alu_regfile_sequencer.sv
// Shared ALU/register-file parameters plus a one-at-a-time sequencer:
// read two sources, execute an 8-bit ALU op, write back and respond.
package alu_pkg;
  localparam int REGFILE_SIZE       = 32;
  localparam int REGFILE_WIDTH      = 16;
  localparam int REGFILE_ADDR_WIDTH = 5;
  localparam int ALU_INPUT_WIDTH    = 8;
  localparam int ALU_OUTPUT_WIDTH   = 9;
  typedef enum logic [2:0] {
    ADD = 3'd0, SUB = 3'd1, SUBA = 3'd2, ORAB = 3'd3,
    ANDAB = 3'd4, NOTAB = 3'd5, EXOR = 3'd6, EXNOR = 3'd7
  } aluop_t;
endpackage

module alu_regfile_sequencer
  import alu_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset_n,
  alu_regfile_sequencer_if.slave        bus,
  input  logic [REGFILE_ADDR_WIDTH-1:0] dbg_addr,
  output logic [REGFILE_WIDTH-1:0]      dbg_data
);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] RD   = 3'd1;
  localparam logic [2:0] EX   = 3'd2;
  localparam logic [2:0] WB   = 3'd3;
  localparam logic [2:0] RSP  = 3'd4;

  logic [2:0]                    state;
  aluop_t                        op_q;
  logic [REGFILE_ADDR_WIDTH-1:0] rd_q, ra_q, rb_q;
  logic [ALU_INPUT_WIDTH-1:0]    a_q, b_q;
  logic [ALU_OUTPUT_WIDTH-1:0]   r_q, alu_res;
  logic [REGFILE_WIDTH-1:0]      rf [REGFILE_SIZE];
  logic                          rsp_valid_q;
  logic [ALU_OUTPUT_WIDTH-1:0]   rsp_result_q;
  logic [REGFILE_ADDR_WIDTH-1:0] rsp_rd_q;

  // A host load wins the IDLE cycle; the command simply waits one more cycle.
  assign bus.cmd_ready  = (state == IDLE) && !bus.ld_en;
  assign bus.ld_ready   = (state == IDLE);
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_rd     = rsp_rd_q;
  assign dbg_data       = rf[dbg_addr];

  always_comb begin
    alu_res = '0;
    case (op_q)
      ADD:     alu_res = {1'b0, a_q} + {1'b0, b_q};
      SUB:     alu_res = {1'b0, a_q} - {1'b0, b_q};
      SUBA:    alu_res = {1'b0, b_q} - {1'b0, a_q};
      ORAB:    alu_res = {1'b0, a_q | b_q};
      ANDAB:   alu_res = {1'b0, a_q & b_q};
      NOTAB:   alu_res = {1'b0, ~(a_q & b_q)};
      EXOR:    alu_res = {1'b0, a_q ^ b_q};
      EXNOR:   alu_res = {1'b0, ~(a_q ^ b_q)};
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      op_q         <= ADD;
      rd_q         <= '0;
      ra_q         <= '0;
      rb_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      r_q          <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_rd_q     <= '0;
      for (int i = 0; i < REGFILE_SIZE; i++) rf[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.ld_en) begin
            rf[bus.ld_addr] <= bus.ld_data;
          end else if (bus.cmd_valid) begin
            op_q  <= aluop_t'(bus.cmd_op);
            rd_q  <= bus.cmd_rd;
            ra_q  <= bus.cmd_ra;
            rb_q  <= bus.cmd_rb;
            state <= RD;
          end
        end
        RD: begin
          // Only the low byte of each register reaches the ALU.
          a_q   <= rf[ra_q][ALU_INPUT_WIDTH-1:0];
          b_q   <= rf[rb_q][ALU_INPUT_WIDTH-1:0];
          state <= EX;
        end
        EX: begin
          r_q   <= alu_res;
          state <= WB;
        end
        WB: begin
          rf[rd_q]     <= {{(REGFILE_WIDTH-ALU_OUTPUT_WIDTH){1'b0}}, r_q};
          rsp_result_q <= r_q;
          rsp_rd_q     <= rd_q;
          rsp_valid_q  <= 1'b1;
          state        <= RSP;
        end
        RSP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
